// File: rtl/alu.sv
// alu: registered 8-operation arithmetic/logic unit with carry and zero flags
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             carry,
  output logic             zero
);
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d, zero_q;
  logic [WIDTH:0]   sum, diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  // the top bit of the extended difference is the borrow (a < b)
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    case (opcode)
      3'd0: {carry_d, out_d} = sum;
      3'd1: {carry_d, out_d} = diff;
      3'd2: out_d = a & b;
      3'd3: out_d = a | b;
      3'd4: out_d = a ^ b;
      3'd5: out_d = ~a;
      3'd6: {carry_d, out_d} = {a, 1'b0};
      default: {out_d, carry_d} = {1'b0, a};
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= (out_d == '0);
    end
  end
  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = zero_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized self-checking bench comparing alu against an arithmetic reference model
module tb_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] out, a = '0, b = '0;
  logic [2:0] opcode = '0;
  logic       carry, zero;
  int         n_chk = 0, n_fail = 0;

  alu dut (
    .clk(clk), .rst(rst), .out(out), .opcode(opcode),
    .a(a), .b(b), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int op, input int x, input int y,
                                output int r, output int c);
    r = 0;
    c = 0;
    case (op)
      0: begin r = (x + y) % 256; c = (x + y) > 255; end
      1: begin r = (x - y + 256) % 256; c = x < y; end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 255 - x;
      6: begin r = (x * 2) % 256; c = x >= 128; end
      default: begin r = x / 2; c = x % 2; end
    endcase
  endfunction

  task automatic step(input string tag, input logic [2:0] op, input logic [7:0] x,
                      input logic [7:0] y);
    int r, c;
    opcode = op;
    a = x;
    b = y;
    model(int'(op), int'(x), int'(y), r, c);
    @(posedge clk);
    #1;
    check({tag, ".out"}, int'(out), r);
    check({tag, ".carry"}, int'(carry), c);
    check({tag, ".zero"}, int'(zero), int'(r == 0));
  endtask

  task automatic expect_reset(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".out"}, int'(out), 0);
    check({tag, ".carry"}, int'(carry), 0);
    check({tag, ".zero"}, int'(zero), 1);
  endtask

  initial begin
    logic [2:0] op;
    void'($urandom(32'd2024));
    a = 8'hFF;
    b = 8'h01;
    opcode = 3'd0;
    rst = 1'b1;
    expect_reset("rst0");
    expect_reset("rst1");
    rst = 1'b0;
    step("rel", 3'd0, 8'hFF, 8'h01);
    step("add", 3'd0, 8'h3C, 8'h05);
    step("sub_borrow", 3'd1, 8'h05, 8'h06);
    step("sub_eq", 3'd1, 8'h77, 8'h77);
    step("and", 3'd2, 8'hA5, 8'h0F);
    step("or", 3'd3, 8'hA5, 8'h0F);
    step("xor", 3'd4, 8'hA5, 8'h0F);
    step("not", 3'd5, 8'hA5, 8'h0F);
    step("shl", 3'd6, 8'h81, 8'h00);
    step("shr", 3'd7, 8'h81, 8'h00);
    step("shr_zero", 3'd7, 8'h01, 8'h33);
    op = 3'd0;
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 4; k++)
        step("sweep", op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      op = op + 3'd1;
    end
    for (int i = 0; i < 3; i++)
      step("stream", 3'd0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    rst = 1'b1;
    a = 8'h90;
    b = 8'h90;
    expect_reset("mid_rst");
    rst = 1'b0;
    step("post_rst", 3'd0, 8'h90, 8'h90);
    step("post_rst2", 3'd0, 8'h12, 8'h34);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit registered arithmetic/logic unit with a 3-bit opcode selecting one of 8 operations on operands a and b.
- Result and status flags are registered on the rising clock edge, so they appear one cycle after the inputs are sampled.
- Used as a datapath leaf block.
- Instantiated positionally in the existing order (out, opcode, a, b) after the clock/reset pair; flag ports follow b.

Parameters:
- WIDTH, 8, operand and result width in bits. Default 8 is the only verified value.

Ports:
- clk     input   1      system clock; all state updates on the rising edge
- rst     input   1      synchronous, active-high reset
- out     output  8      registered operation result
- opcode  input   3      operation select
- a       input   8      operand A (unsigned)
- b       input   8      operand B (unsigned)
- carry   output  1      registered carry/borrow/shift-out flag
- zero    output  1      registered flag, 1 when the registered out == 0

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- rst=1 at a rising edge: out=8'h00, carry=0, zero=1. Reset has priority over any opcode.
- Otherwise, each rising edge: out <= f(opcode,a,b); flags are updated the same edge. Latency is 1 cycle; the bench samples after the edge.
- Opcode map:
  - 0: ADD, out=a+b mod 256; carry=bit 8 of the 9-bit sum.
  - 1: SUB, out=a-b mod 256; carry=1 when a<b (borrow).
  - 2: AND, out=a&b; carry=0.
  - 3: OR, out=a|b; carry=0.
  - 4: XOR, out=a^b; carry=0.
  - 5: NOT, out=~a; b ignored; carry=0.
  - 6: SHL, out=a<<1 with LSB 0; carry=a[7]; b ignored.
  - 7: SHR, out=a>>1 with MSB 0 (logical); carry=a[0]; b ignored.
- zero = (next out == 0) for every opcode.
- Arithmetic is unsigned, modulo 2^WIDTH. No overflow flag. No saturation.
- The operation is fully combinational ahead of the output register. There is no handshake and no multi-cycle op; a new operation can be issued every cycle.
- Inputs changing between edges have no effect until the next edge.
- Opcode wrap: the opcode is a 3-bit value, so an increment from 7 returns to 0 (ADD). No illegal opcodes exist.
- X/Z on inputs is not handled specially.
- Reset asserted mid-stream clears the outputs at that edge. Normal operation resumes at the first edge with rst=0.

Test Plan:
- Reset: rst=1 for 2 cycles with a=8'hFF, b=8'h01, opcode=0 -> out=8'h00, carry=0, zero=1. Release rst -> the next edge gives out=8'h00, carry=1, zero=1.
- ADD/SUB: ADD a=8'h3C, b=8'h05 -> out=8'h41, carry=0. SUB a=8'h05, b=8'h06 -> out=8'hFF, carry=1, zero=0. SUB a=b=8'h77 -> out=8'h00, zero=1.
- Logic: a=8'hA5, b=8'h0F:
  - AND -> 8'h05
  - OR -> 8'hAF
  - XOR -> 8'hAA
  - NOT -> 8'h5A
  - carry=0 on all four.
- Shifts: a=8'h81:
  - SHL -> out=8'h02, carry=1
  - SHR -> out=8'h40, carry=1
  - a=8'h01 SHR -> out=8'h00, zero=1, carry=1
- Opcode sweep: random a, b (fixed seed), opcode stepped 0..7 and then wrapped to 0, held several cycles each. Every cycle, out and flags match the reference model of the previous cycle's inputs.
- Mid-operation reset: stream ADDs, assert rst for one cycle -> reset values on that edge only; the following edge shows the ADD result of the current inputs.
